// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and line-base helper for the VGA framebuffer arbiter.
package vga_pkg;

    localparam int H_PIXELS       = 640;
    localparam int V_LINES        = 480;
    localparam int DATA_W         = 12;
    localparam int ADDR_W         = 19;
    localparam int WR_SLOT_PERIOD = 8;
    localparam int SLOT_W         = $clog2(WR_SLOT_PERIOD);
    localparam int X_W            = 10;
    localparam int LB_ADDR_W      = X_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } arb_state_t;

    // 640 = 512 + 128, so the default geometry needs only two shifts and an adder.
    function automatic logic [ADDR_W-1:0] line_base(input logic [8:0] idx);
        logic [ADDR_W-1:0] w;
        w = ADDR_W'(idx);
        if (H_PIXELS == 640)
            return (w << 9) + (w << 7);
        else
            return w * ADDR_W'(H_PIXELS);
    endfunction

endpackage

// File: rtl/vga_fb_fetch_ctr.sv
// Line fetch address generator: x counter, base adder and the two-stage
// pipeline that turns an issued RAM read into a line-buffer write.
import vga_pkg::*;

module vga_fb_fetch_ctr (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [8:0]           line_idx,
    input  logic                 issue,
    output logic [ADDR_W-1:0]    fetch_addr,
    output logic                 last,
    output logic                 lb_we,
    output logic [LB_ADDR_W-1:0] lb_addr
);

    logic [ADDR_W-1:0] base;
    logic [X_W-1:0]    x;
    logic              bank;
    logic              pend_valid;
    logic [X_W-1:0]    pend_x;

    assign fetch_addr = base + ADDR_W'(x);
    assign last       = (x == X_W'(H_PIXELS - 1));

    // pend_* tracks the read whose address is on the RAM bus; its data
    // arrives one cycle later, which is when the line-buffer write fires.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            base       <= '0;
            x          <= '0;
            bank       <= 1'b0;
            pend_valid <= 1'b0;
            pend_x     <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
        end else begin
            if (start) begin
                base <= line_base(line_idx);
                x    <= '0;
                bank <= line_idx[0];
            end else if (issue) begin
                x <= x + X_W'(1);
            end

            pend_valid <= issue;
            if (issue)
                pend_x <= x;

            lb_we <= pend_valid;
            if (pend_valid)
                lb_addr <= {bank, pend_x};
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display line prefetch has priority, the pixel
// writer takes every free slot. Define VGA_FB_ARB_WR_SLOT_EN for writer guard slots during fetch.
import vga_pkg::*;

module vga_fb_arbiter (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 LINE_REQ,
    input  logic [8:0]           LINE_IDX,
    output logic                 LINE_BUSY,
    output logic                 LINE_DONE,
    output logic                 ERR,
    input  logic                 ERR_CLR,
    input  logic                 WR_REQ,
    input  logic [ADDR_W-1:0]    WR_ADDR,
    input  logic [DATA_W-1:0]    WR_DATA,
    output logic                 WR_ACK,
    output logic [ADDR_W-1:0]    MEM_ADDR,
    output logic                 MEM_WE,
    output logic [DATA_W-1:0]    MEM_WDATA,
    input  logic [DATA_W-1:0]    MEM_RDATA,
    output logic                 LB_WE,
    output logic [LB_ADDR_W-1:0] LB_ADDR,
    output logic [DATA_W-1:0]    LB_DATA
);

    arb_state_t        state;
    logic              accept;
    logic              bad_req;
    logic              guard;
    logic              fetch_owns;
    logic              wr_grant;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_last;

    assign LB_DATA = MEM_RDATA;

    assign accept  = LINE_REQ && (state == IDLE) && !LINE_BUSY && (LINE_IDX < 9'(V_LINES));
    assign bad_req = LINE_REQ && !accept;

`ifdef VGA_FB_ARB_WR_SLOT_EN
    logic [SLOT_W-1:0] slot_cnt;

    assign guard = (state == FETCH) && (slot_cnt == SLOT_W'(WR_SLOT_PERIOD - 1));

    // Free-running within a fetch so every WR_SLOT_PERIOD-th slot is offered to the writer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            slot_cnt <= '0;
        else if (state != FETCH)
            slot_cnt <= '0;
        else if (slot_cnt == SLOT_W'(WR_SLOT_PERIOD - 1))
            slot_cnt <= '0;
        else
            slot_cnt <= slot_cnt + SLOT_W'(1);
    end
`else
    assign guard = 1'b0;
`endif

    assign fetch_owns = (state == FETCH) && !(guard && WR_REQ);
    assign wr_grant   = WR_REQ && !fetch_owns;

    vga_fb_fetch_ctr u_fetch_ctr (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (accept),
        .line_idx   (LINE_IDX),
        .issue      (fetch_owns),
        .fetch_addr (fetch_addr),
        .last       (fetch_last),
        .lb_we      (LB_WE),
        .lb_addr    (LB_ADDR)
    );

    // LINE_BUSY stays high through the LINE_DONE cycle and drops on the next edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            MEM_ADDR  <= '0;
            MEM_WE    <= 1'b0;
            MEM_WDATA <= '0;
            WR_ACK    <= 1'b0;
            LINE_BUSY <= 1'b0;
            LINE_DONE <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            WR_ACK    <= wr_grant;
            LINE_DONE <= 1'b0;

            if (fetch_owns) begin
                MEM_ADDR <= fetch_addr;
                MEM_WE   <= 1'b0;
            end else if (wr_grant) begin
                MEM_ADDR  <= WR_ADDR;
                MEM_WDATA <= WR_DATA;
                MEM_WE    <= 1'b1;
            end else begin
                MEM_WE <= 1'b0;
            end

            if (bad_req)
                ERR <= 1'b1;
            else if (ERR_CLR)
                ERR <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= FETCH;
                        LINE_BUSY <= 1'b1;
                    end else if (LINE_DONE) begin
                        LINE_BUSY <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fetch_owns && fetch_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    state     <= IDLE;
                    LINE_DONE <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
